// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline hazard/stall controller. Turns ID/EX stall requests
//            into a per-stage hold vector. A watchdog forces a one-cycle
//            release after WDOG_LIMIT consecutive stalled cycles. Optional
//            performance counters track stalled and bubble cycles.
// Config   : define PIPE_CTRL_PERF_EN to build the perf counters; otherwise
//            stall_cycles/bubble_cycles are tied to zero and no flops exist.
// Ports    : clk, rst (sync, active-high)
//            stallreq_id, stallreq_ex   - stage stall requests (level)
//            wdog_en                    - enable forced-release watchdog
//            clear_stats                - clear timeout flag and counters
//            stall[5:0]                 - hold vector PC,IF,ID,EX,MEM,WB
//            ctrl_state[1:0]            - 0 RUN,1 HOLD_ID,2 HOLD_EX,3 RELEASE
//            stall_timeout              - sticky watchdog-fired flag
//            stall_cycles, bubble_cycles- 32-bit saturating perf counters
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int WDOG_LIMIT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        wdog_en,
  input  logic        clear_stats,
  output logic [5:0]  stall,
  output logic [1:0]  ctrl_state,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] bubble_cycles
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD_ID = 2'd1,
    ST_HOLD_EX = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [5:0]  c_STALL_NONE = 6'b000000;
  localparam logic [5:0]  c_STALL_ID   = 6'b000111;
  localparam logic [5:0]  c_STALL_EX   = 6'b001111;
  localparam logic [15:0] c_WDOG_MAX   = 16'(WDOG_LIMIT - 1);
  localparam logic [15:0] c_RUN_SAT    = 16'hFFFF;

  state_t      r_state;
  logic [15:0] r_run_len;
  logic        r_timeout;
  logic [5:0]  w_stall;
  logic        w_stalled;
  logic        w_fire;

  // Hold vector is purely combinational so the stage registers see it in the
  // same cycle as the request. Reset and the release cycle override requests.
  always_comb begin
    w_stall = c_STALL_NONE;
    if (rst || (r_state == ST_RELEASE)) begin
      w_stall = c_STALL_NONE;
    end else if (stallreq_ex) begin
      w_stall = c_STALL_EX;
    end else if (stallreq_id) begin
      w_stall = c_STALL_ID;
    end
  end

  assign w_stalled = (w_stall != c_STALL_NONE);
  // run_len counts stalled cycles before this one, so it fires on the
  // WDOG_LIMIT-th consecutive stalled cycle.
  assign w_fire    = wdog_en && w_stalled && (r_run_len == c_WDOG_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_run_len <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      if (w_fire) begin
        r_state <= ST_RELEASE;
      end else if (w_stall == c_STALL_EX) begin
        r_state <= ST_HOLD_EX;
      end else if (w_stall == c_STALL_ID) begin
        r_state <= ST_HOLD_ID;
      end else begin
        r_state <= ST_RUN;
      end

      // ID<->EX handover without an idle cycle keeps counting.
      if (w_fire || !w_stalled) begin
        r_run_len <= 16'd0;
      end else if (r_run_len != c_RUN_SAT) begin
        r_run_len <= r_run_len + 16'd1;
      end

      // Firing takes priority over a coincident clear.
      if (w_fire) begin
        r_timeout <= 1'b1;
      end else if (clear_stats) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign stall         = w_stall;
  assign ctrl_state    = r_state;
  assign stall_timeout = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [31:0] c_CNT_SAT = 32'hFFFF_FFFF;

  logic [31:0] r_stall_cycles;
  logic [31:0] r_bubble_cycles;

  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      r_stall_cycles  <= 32'd0;
      r_bubble_cycles <= 32'd0;
    end else begin
      if (w_stalled && (r_stall_cycles != c_CNT_SAT)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      // A bubble is inserted into EX only when ID alone is held.
      if ((w_stall == c_STALL_ID) && (r_bubble_cycles != c_CNT_SAT)) begin
        r_bubble_cycles <= r_bubble_cycles + 32'd1;
      end
    end
  end

  assign stall_cycles  = r_stall_cycles;
  assign bubble_cycles = r_bubble_cycles;
`else
  assign stall_cycles  = 32'h0;
  assign bubble_cycles = 32'h0;
`endif

endmodule
`default_nettype wire
